fp_issue_ctrl: RTL
==================

Name: fp_issue_ctrl

Overview:
- Responder side of the 4-way FP-unit arbiter: consumes the one-hot grant, captures the granted requester's operands and opcode, and issues one operation to the shared multi-cycle FPU.
- Drives `busy` back to the arbiter so the grant is frozen while a transaction is in flight.
- Routes the FPU result back to the granted requester and holds it until that requester acknowledges.
- Includes a watchdog timer that terminates a hung FPU operation with an error response.

Parameters:
- DW, 32, operand/result width
- OPW, 4, opcode width
- TIMEOUT, 64, maximum cycles to wait for fpu_done (≥2)
- TW, $clog2(TIMEOUT), timer width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- gnt  in  4  one-hot grant from arbiter (bit i = requester i)
- req  in  4  request lines (same lines that feed the arbiter)
- req_a  in  4*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  4*DW  operand B, same packing
- req_op  in  4*OPW  opcode, requester i at [i*OPW +: OPW]
- busy  out  1  high while a transaction is in flight; goes to arbiter
- fpu_start  out  1  one-cycle issue pulse
- fpu_a  out  DW  captured operand A
- fpu_b  out  DW  captured operand B
- fpu_op  out  OPW  captured opcode
- fpu_done  in  1  FPU completion pulse
- fpu_result  in  DW  FPU result, valid with fpu_done
- rsp_valid  out  4  one-hot response valid toward requester
- rsp_data  out  DW  response data (shared bus)
- rsp_err  out  1  response is a timeout error
- rsp_ack  in  4  per-requester response acknowledge

Behaviour:
- Reset values: state IDLE; busy, fpu_start, rsp_valid, rsp_err = 0; fpu_a, fpu_b, fpu_op, rsp_data, timer, captured index = 0.
- Reset mid-operation aborts immediately. An fpu_done arriving after reset is ignored because the block is in IDLE.
- busy is a registered output: busy = (state != IDLE).
- IDLE:
  - Let hit = gnt & req.
  - If hit != 0: capture the lowest set bit of hit as idx, latch req_a/req_b/req_op[idx] into fpu_a/fpu_b/fpu_op, go to ISSUE.
  - gnt with multiple bits set: lowest index among hit wins.
  - hit == 0 (no grant, or grant to a non-requesting line): stay in IDLE.
- ISSUE: fpu_start = 1 for exactly this cycle; clear timer; go to WAIT. fpu_done in this cycle is ignored.
- WAIT:
  - Timer increments each cycle.
  - If fpu_done: rsp_data <= fpu_result, rsp_err <= 0, go to RESP.
  - Else if timer == TIMEOUT-1: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - fpu_done and timeout in the same cycle: fpu_done wins (no error).
- RESP:
  - rsp_valid[idx] = 1, all other bits 0; rsp_data and rsp_err are held stable.
  - rsp_ack[idx] high: go to IDLE; rsp_valid clears and busy deasserts the next cycle.
  - rsp_ack on any other bit is ignored.
  - fpu_done pulses in RESP or IDLE are ignored.
- Timing: capture at edge E0 → fpu_start high in cycle 1 → WAIT from cycle 2. fpu_done in cycle 2 gives rsp_valid in cycle 3. rsp_ack in cycle 3 gives busy = 0 in cycle 4.
- Minimum occupancy is 4 cycles per transaction. Back-to-back: a new capture is possible in the first IDLE cycle (cycle 4).
- Operand inputs are sampled only at capture; later changes have no effect on the transaction in flight.
- fpu_a/fpu_b/fpu_op hold their last values until the next capture.

Test Plan:
- Reset, then req=4'b0100, gnt=4'b0100, req_a=0x3F800000, req_b=0x40000000 for lane 2:
  - fpu_start pulses in cycle 1 with those operands.
  - fpu_done with result 0x40400000 in cycle 2 → rsp_valid=4'b0100, rsp_data=0x40400000, rsp_err=0 in cycle 3.
  - ack in cycle 3 → busy=0 in cycle 4.
- Timeout with TIMEOUT=8: never assert fpu_done → rsp_valid[idx] and rsp_err=1 with rsp_data=0, exactly 8 WAIT cycles after fpu_start; busy stays high until ack.
- fpu_done in the same cycle as timer==TIMEOUT-1 → rsp_err=0 and rsp_data=fpu_result.
- Wrong-lane ack: idx=1, drive rsp_ack=4'b0001 for 3 cycles → rsp_valid stays 4'b0010; then rsp_ack=4'b0010 → released next cycle.
- gnt=4'b1000 with req=4'b0000 → no capture, busy stays 0. gnt=4'b0110 with req=4'b0110 → lane 1 captured.
- Assert rst_n low during WAIT → all outputs 0 asynchronously; a later fpu_done produces no rsp_valid. A new grant after reset works normally.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// FP issue controller: takes the arbiter grant, issues one op to the shared
// FPU, routes the result (or a watchdog error) back to the granted requester.
module fp_issue_ctrl #(
    parameter int DW      = 32,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     gnt,
    input  logic [3:0]     req,
    input  logic [4*DW-1:0]  req_a,
    input  logic [4*DW-1:0]  req_b,
    input  logic [4*OPW-1:0] req_op,
    output logic           busy,
    output logic           fpu_start,
    output logic [DW-1:0]  fpu_a,
    output logic [DW-1:0]  fpu_b,
    output logic [OPW-1:0] fpu_op,
    input  logic           fpu_done,
    input  logic [DW-1:0]  fpu_result,
    output logic [3:0]     rsp_valid,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    input  logic [3:0]     rsp_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t         state_q;
    logic [1:0]     idx_q;
    logic [TW-1:0]  timer_q;
    logic           busy_q;
    logic           start_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [OPW-1:0] op_q;
    logic [3:0]     valid_q;
    logic [DW-1:0]  data_q;
    logic           err_q;

    logic [3:0]     hit;
    logic [1:0]     lo_idx;

    // Lowest-index requester among those both granted and requesting
    always_comb begin
        hit    = gnt & req;
        lo_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) lo_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|hit) begin
                        idx_q   <= lo_idx;
                        a_q     <= req_a[int'(lo_idx)*DW +: DW];
                        b_q     <= req_b[int'(lo_idx)*DW +: DW];
                        op_q    <= req_op[int'(lo_idx)*OPW +: OPW];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A completion on the last allowed cycle still counts
                    if (fpu_done) begin
                        data_q  <= fpu_result;
                        err_q   <= 1'b0;
                        valid_q <= 4'b0001 << idx_q;
                        state_q <= RESP;
                    end else if (timer_q == TLAST) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 4'b0001 << idx_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack[idx_q]) begin
                        valid_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign fpu_start = start_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign fpu_op    = op_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule
